// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the fifo push arbiter.
package fifo_arb_pkg;

    localparam int unsigned OWNER_W   = 3;
    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned STAT_W    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Advance a requester index by one, wrapping at n.
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] v,
                                                   input int unsigned n);
        return ((32'(v) + 32'd1) >= n) ? '0 : v + OWNER_W'(1);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer/fifo-side signal bundle of the fifo push arbiter.
// Stats ports exist only when FIFO_ARB_STATS_EN is defined.
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        gnt;
    logic                    fifo_push;
    logic [DATA_W-1:0]       fifo_data;
    logic                    fifo_full;
    logic                    fifo_err;
    logic [OWNER_W-1:0]      owner;
    logic                    busy;
    logic [ERR_CNT_W-1:0]    err_cnt;
`ifdef FIFO_ARB_STATS_EN
    logic [2:0]              stat_sel;
    logic [STAT_W-1:0]       stat_cnt;

    modport master (
        input  req, req_data, req_last, fifo_full, fifo_err, stat_sel,
        output gnt, fifo_push, fifo_data, owner, busy, err_cnt, stat_cnt
    );
    modport slave (
        output req, req_data, req_last, fifo_full, fifo_err, stat_sel,
        input  gnt, fifo_push, fifo_data, owner, busy, err_cnt, stat_cnt
    );
`else
    modport master (
        input  req, req_data, req_last, fifo_full, fifo_err,
        output gnt, fifo_push, fifo_data, owner, busy, err_cnt
    );
    modport slave (
        output req, req_data, req_last, fifo_full, fifo_err,
        input  gnt, fifo_push, fifo_data, owner, busy, err_cnt
    );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req at or after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] rr_ptr,
    output logic [OWNER_W-1:0] pick,
    output logic               any
);
    logic [N_REQ-1:0]   rot;
    logic [OWNER_W-1:0] off;
    logic [OWNER_W:0]   sum;

    // Rotate so rr_ptr lands at bit 0; lowest set bit is then the winner.
    assign rot = N_REQ'({req, req} >> rr_ptr);
    assign any = |req;

    always_comb begin
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = OWNER_W'(j);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (OWNER_W + 1)'(N_REQ)) sum = sum - (OWNER_W + 1)'(N_REQ);
        pick = sum[OWNER_W-1:0];
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-granular sharing of one fifo push port among N_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester beat counters and stat_sel/stat_cnt.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.master bus
);
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BEAT_W = 4;

    state_t              state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ERR_CNT_W-1:0] err_q;
    logic [OWNER_W-1:0]  pick;
    logic                any;
    logic [IDX_W-1:0]    own_idx;
    logic                own_req, own_last, accept_c;
    logic [N_REQ-1:0]    gnt_c;
    logic [DATA_W-1:0]   data_c;

    assign own_idx  = owner_q[IDX_W-1:0];
    assign own_req  = bus.req[own_idx];
    assign own_last = bus.req_last[own_idx];
    assign accept_c = (state_q == BURST) && own_req && !bus.fifo_full;
    assign gnt_c    = accept_c ? (N_REQ'(1) << own_idx) : '0;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .any    (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    // Grant held until last beat, BURST_MAX beats, or owner drops req.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d = pick;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept_c) beat_d = beat_q + BEAT_W'(1);
                if (!own_req ||
                    (accept_c && (own_last || beat_q == BEAT_W'(BURST_MAX - 1)))) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(owner_q, N_REQ);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_q <= '0;
        else if (bus.fifo_err && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
    end

    // Owner's data is presented even while stalled.
    always_comb begin
        data_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (own_idx == IDX_W'(i)) data_c = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.fifo_push = accept_c;
    assign bus.fifo_data = data_c;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.err_cnt   = err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_c[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_comb begin
        bus.stat_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.stat_sel == 3'(i)) bus.stat_cnt = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized bench for fifo_push_arbiter: producer engine, fifo sink and a
// burst-level reference model compared against the DUT every cycle.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BM    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Producer state: each requester offers p_data[i][p_pos..p_len-1].
    logic [DW-1:0] p_data [N][16];
    int            p_len  [N];
    int            p_pos  [N];
    bit            p_uselast [N];
    bit            rnd_mode = 0;
    int            abandon_pct = 0;
    logic [N-1:0]  g_seen = '0;

    // Fifo sink.
    logic [DW-1:0] sq [$];
    logic          s_full = 1'b0;
    logic          s_err = 1'b0;
    bit            s_push = 0;
    logic [DW-1:0] s_data = '0;
    int            pop_pct = 0;
    int            ovf = 0;

    assign bus.fifo_full = s_full;
    assign bus.fifo_err  = s_err;

    // Reference model.
    bit m_busy;
    int m_owner, m_ptr, m_beats, m_err;
    int m_stat [N];
    int gcnt [N];
    int log_owner [$];
    int log_beats [$];

    initial begin : sink_proc
        int pre;
        bit pop;
        forever begin
            @(posedge clk);
            pre = sq.size();
            pop = int'($urandom_range(0, 99)) < pop_pct;
            if (pop && pre > 0) void'(sq.pop_front());
            if (s_push) begin
                if (pre >= DEPTH) ovf++;
                else sq.push_back(s_data);
            end
            s_err  <= (pop && pre == 0) || (s_push && pre >= DEPTH);
            s_full <= (sq.size() >= DEPTH);
        end
    end

    initial begin : cmp_proc
        logic [N-1:0] eg;
        bit acc;
        int pk;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_err = 0;
                for (int i = 0; i < N; i++) m_stat[i] = 0;
                g_seen = '0;
                s_push = 0;
            end else begin
                acc = m_busy && bus.req[m_owner] && !bus.fifo_full;
                eg  = acc ? (N'(1) << m_owner) : '0;
                chk("gnt", 32'(bus.gnt), 32'(eg));
                chk("fifo_push", 32'(bus.fifo_push), 32'(acc));
                chk("busy", 32'(bus.busy), 32'(m_busy));
                if (m_busy) chk("owner", 32'(bus.owner), m_owner);
                if (acc) chk("fifo_data", 32'(bus.fifo_data), 32'(p_data[m_owner][p_pos[m_owner]]));
                chk("err_cnt", 32'(bus.err_cnt), m_err);
`ifdef FIFO_ARB_STATS_EN
                chk("stat_cnt", 32'(bus.stat_cnt), m_stat[bus.stat_sel]);
`endif
                g_seen = bus.gnt;
                s_push = bus.fifo_push;
                s_data = bus.fifo_data;
                if (bus.fifo_err && m_err < 255) m_err++;
                for (int i = 0; i < N; i++) begin
                    if (eg[i]) begin
                        gcnt[i]++;
                        if (m_stat[i] < 65535) m_stat[i]++;
                    end
                end
                if (!m_busy) begin
                    pk = -1;
                    for (int k = N - 1; k >= 0; k--) if (bus.req[(m_ptr + k) % N]) pk = (m_ptr + k) % N;
                    if (pk >= 0) begin
                        m_busy = 1; m_owner = pk; m_beats = 0;
                        log_owner.push_back(pk);
                    end
                end else begin
                    if (acc) m_beats++;
                    if (!bus.req[m_owner] || (acc && (bus.req_last[m_owner] || m_beats == BM))) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                        log_beats.push_back(m_beats);
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]      = p_pos[i] < p_len[i];
            bus.req_last[i] = p_uselast[i] && (p_pos[i] == p_len[i] - 1);
            bus.req_data[i*DW +: DW] = (p_pos[i] < p_len[i]) ? p_data[i][p_pos[i]] : '0;
        end
    endtask

    task automatic load(int i, int len, bit uselast, logic [DW-1:0] d0, logic [DW-1:0] dstep);
        p_pos[i] = 0;
        p_len[i] = len;
        p_uselast[i] = uselast;
        for (int k = 0; k < 16; k++) p_data[i][k] = d0 + DW'(k) * dstep;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (g_seen[i]) p_pos[i]++;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (p_pos[i] >= p_len[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        load(i, int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                             DW'($urandom), DW'($urandom));
                end else if (!g_seen[i] && int'($urandom_range(0, 99)) < abandon_pct) begin
                    p_len[i] = p_pos[i];
                end
            end
        end
`ifdef FIFO_ARB_STATS_EN
        bus.stat_sel = 3'($urandom_range(0, N - 1));
`endif
        drive();
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < N; i++) if (p_pos[i] < p_len[i]) return 0;
        return 1;
    endfunction

    task automatic wait_done(int budget, string nm);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = all_drained() && !bus.busy;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    function automatic int owner_at(int k);
        return (log_owner.size() > k) ? log_owner[k] : -1;
    endfunction

    function automatic int beats_at(int k);
        return (log_beats.size() > k) ? log_beats[k] : -1;
    endfunction

    initial begin : main
        logic [DW-1:0] e1 [3];
        int err_before, n0, nb, c;
        bit ok;
        e1[0] = 8'h11; e1[1] = 8'h22; e1[2] = 8'h33;
        for (int i = 0; i < N; i++) begin p_len[i] = 0; p_pos[i] = 0; p_uselast[i] = 0; end
`ifdef FIFO_ARB_STATS_EN
        bus.stat_sel = '0;
`endif
        drive();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_push", 32'(bus.fifo_push), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        #1 rst = 1'b0;

        // Single producer, three beats with last.
        load(0, 3, 1, 8'h11, 8'h11);
        drive();
        wait_done(30, "s1_done");
        chk("s1_gnt0_beats", gcnt[0], 3);
        chk("s1_fifo_level", sq.size(), 3);
        for (int k = 0; k < 3; k++) if (sq.size() > k) chk("s1_fifo_word", 32'(sq[k]), 32'(e1[k]));
        chk("s1_log_owner", owner_at(0), 0);
        chk("s1_log_beats", beats_at(0), 3);

        // rr_ptr must now be 1: req1 beats req0.
        load(0, 1, 1, 8'h40, 8'h01);
        load(1, 1, 1, 8'h50, 8'h01);
        drive();
        wait_done(30, "pin_done");
        chk("pin_first", owner_at(1), 1);
        chk("pin_second", owner_at(2), 0);

        // All four hold 8 beats without last: BURST_MAX-limited rotation.
        pop_pct = 60;
        for (int i = 0; i < N; i++) load(i, 8, 0, DW'(8'h10 * (i + 1)), 8'h01);
        drive();
        wait_done(300, "s2_done");
        for (int k = 0; k < 8; k++) begin
            chk("s2_order", owner_at(3 + k), (1 + k) % N);
            chk("s2_burst_len", beats_at(3 + k), BM);
        end
`ifdef FIFO_ARB_STATS_EN
        bus.stat_sel = 3'd0;
        #1 chk("s2_stat_req0", 32'(bus.stat_cnt), 32'd12);
`endif

        // Fill to 16 mid-burst of req2 and stall.
        pop_pct = 100;
        repeat (25) step();
        pop_pct = 0;
        repeat (3) step();
        err_before = int'(bus.err_cnt);
        load(1, 14, 1, 8'h60, 8'h01);
        drive();
        wait_done(60, "s3_prefill");
        load(2, 4, 0, 8'hA0, 8'h01);
        drive();
        ok = 0;
        for (c = 0; c < 40 && !ok; c++) begin step(); ok = s_full; end
        chk("s3_filled", 32'(ok), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s3_stall_gnt", 32'(bus.gnt), 32'd0);
            chk("s3_stall_push", 32'(bus.fifo_push), 32'd0);
        end
        chk("s3_stall_busy", 32'(bus.busy), 32'd1);
        chk("s3_stall_owner", 32'(bus.owner), 32'd2);
        pop_pct = 100;
        step();
        pop_pct = 0;
        chk("s3_resume_gnt", 32'(bus.gnt), 32'b0100);
        repeat (3) step();
        chk("s3_no_err", 32'(bus.err_cnt), err_before);
        chk("s3_no_overflow", ovf, 0);
        pop_pct = 100;
        wait_done(60, "s3_done");
        repeat (20) step();

        // Owner abandons after one beat; pending req2 goes next.
        pop_pct = 50;
        load(1, 3, 1, 8'hB0, 8'h01);
        drive();
        ok = 0;
        for (c = 0; c < 30 && !ok; c++) begin step(); ok = p_pos[1] >= 1; end
        chk("s4_first_beat", 32'(ok), 32'd1);
        n0 = log_owner.size();
        nb = log_beats.size();
        load(2, 2, 1, 8'hC0, 8'h01);
        p_len[1] = p_pos[1];
        drive();
        wait_done(40, "s4_done");
        chk("s4_abandon_beats", beats_at(nb), 1);
        chk("s4_next_owner", owner_at(n0), 2);

        // Reset mid-burst of req3 while req0 waits.
        load(3, 3, 0, 8'hD0, 8'h01);
        drive();
        ok = 0;
        for (c = 0; c < 30 && !ok; c++) begin step(); ok = p_pos[3] >= 1; end
        chk("s5_req3_started", 32'(ok), 32'd1);
        load(0, 2, 1, 8'hE0, 8'h01);
        drive();
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_busy", 32'(bus.busy), 32'd0);
        chk("s5_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("s5_rst_push", 32'(bus.fifo_push), 32'd0);
        chk("s5_rst_owner", 32'(bus.owner), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        chk("s5_rst_stat", 32'(bus.stat_cnt), 32'd0);
`endif
        p_len[3] = p_pos[3];
        drive();
        @(posedge clk);
        #2 rst = 1'b0;
        n0 = log_owner.size();
        wait_done(40, "s5_done");
        chk("s5_first_after_rst", owner_at(n0), 0);

        // Random traffic with abandons and varying fifo drain rate.
        rnd_mode = 1;
        abandon_pct = 3;
        for (int blk = 0; blk < 15; blk++) begin
            pop_pct = int'($urandom_range(10, 90));
            repeat (100) step();
        end
        rnd_mode = 0;
        wait_done(400, "rnd_done");

        // Drain, then pop an empty fifo 300 times.
        pop_pct = 100;
        repeat (20) step();
        repeat (300) step();
        pop_pct = 0;
        repeat (3) step();
        chk("s6_err_saturated", 32'(bus.err_cnt), 32'd255);
        chk("s6_no_overflow", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
